// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core.
//   - Resolves IF/ID/EX/MEM stall requests into the shared stall[5:0] hold vector.
//   - Sequences exception/ERET flushes: flush + new_pc for FLUSH_CYCLES cycles.
//   - Stall watchdog (sticky timeout_err) and saturating stall-cycle counter.
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous active-low reset
//   stallreq_if    fetch bus not ready
//   stallreq_id    ID load-use hazard
//   stallreq_ex    EX multi-cycle op busy
//   stallreq_mem   data bus not ready
//   excepttype     exception code from MEM, 0 = none, 32'h0e = ERET
//   cp0_epc        current EPC, ERET target
//   stall          hold vector: bit0 PC .. bit5 WB
//   flush          clear all pipeline registers, PC loads new_pc
//   new_pc         redirect target, valid while flush=1
//   timeout_err    sticky watchdog flag
//   stall_cycles   saturating count of cycles with stall != 0
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter logic [31:0] EXC_VEC       = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout_err,
  output logic [31:0] stall_cycles
);

  localparam logic [31:0] ExcEret   = 32'h0000_000e;
  localparam logic [3:0]  FlushInit = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WdLimit   = 16'(STALL_TIMEOUT);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e      state_q;
  logic [3:0]  flush_cnt_q;
  logic [31:0] new_pc_q;
  logic [15:0] wd_cnt_q;
  logic        timeout_err_q;
  logic [31:0] stall_cycles_q;

  logic        exc_accept;
  logic [31:0] exc_target;
  logic [5:0]  stall_req;

  always_comb begin
    // Gated by rst so nothing leaks out combinationally while reset is held.
    exc_accept = rst && (state_q == StRun) && (excepttype != '0);
    exc_target = (excepttype == ExcEret) ? cp0_epc : EXC_VEC;

    // Highest-index requester wins; each holds its own stage and all earlier ones.
    if (stallreq_mem)     stall_req = 6'b011111;
    else if (stallreq_ex) stall_req = 6'b001111;
    else if (stallreq_id) stall_req = 6'b000111;
    else if (stallreq_if) stall_req = 6'b000011;
    else                  stall_req = 6'b000000;

    flush = exc_accept || (state_q == StFlush);

    if (state_q == StFlush) new_pc = new_pc_q;
    else if (exc_accept)    new_pc = exc_target;
    else                    new_pc = '0;

    // A flush clears the pipeline, so holding stages would be meaningless.
    stall = (flush || !rst) ? 6'b000000 : stall_req;
  end

  assign timeout_err  = timeout_err_q;
  assign stall_cycles = stall_cycles_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StRun;
      flush_cnt_q    <= '0;
      new_pc_q       <= '0;
      wd_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (exc_accept) begin
            new_pc_q    <= exc_target;
            flush_cnt_q <= FlushInit;
            // The accept cycle is itself the first flush cycle.
            if (FLUSH_CYCLES > 1) state_q <= StFlush;
          end
        end
        StFlush: begin
          // Leave when this cycle is the last remaining one; excepttype is ignored here.
          if (flush_cnt_q <= 4'd1) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            new_pc_q    <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: state_q <= StRun;
      endcase

      // Watchdog counts consecutive stalled cycles and saturates at the limit.
      if ((stall == 6'b000000) || flush) begin
        wd_cnt_q <= '0;
      end else if (wd_cnt_q != WdLimit) begin
        wd_cnt_q <= wd_cnt_q + 16'd1;
        if (wd_cnt_q + 16'd1 == WdLimit) timeout_err_q <= 1'b1;
      end

      if ((stall != 6'b000000) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core. Arbitrates stall requests from the IF, ID, EX and MEM stages into the shared stall[5:0] vector consumed by pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb).
- Sequences exception/ERET flushes: drives flush and new_pc for a programmable number of cycles.
- Runs a stall watchdog and a stall-cycle performance counter.

Parameters:
- FLUSH_CYCLES, 1, cycles flush stays asserted per accepted exception (1..15).
- STALL_TIMEOUT, 1024, consecutive stalled cycles before timeout_err sets (2..65535).
- EXC_VEC, 32'h00000040, handler entry address for all non-ERET exceptions.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_if  in  1  fetch bus not ready.
- stallreq_id  in  1  ID load-use hazard.
- stallreq_ex  in  1  EX multi-cycle op (div/madd) busy.
- stallreq_mem  in  1  data bus not ready.
- excepttype  in  32  exception code from MEM stage; 0 = none.
- cp0_epc  in  32  current EPC, target for ERET.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush  out  1  clear all pipeline registers; PC loads new_pc.
- new_pc  out  32  redirect target, valid while flush=1.
- timeout_err  out  1  sticky watchdog flag.
- stall_cycles  out  32  saturating count of cycles with stall!=0.

Behaviour:
- Reset (rst=0, async): state=RUN; flush=0; new_pc=0; stall=0; timeout_err=0; stall_cycles=0; flush and watchdog counters=0. Reset mid-flush aborts the flush immediately.
- FSM states: RUN, FLUSH.
- Stall vector, combinational, zero latency.
  - Highest-index requester wins: mem -> 6'b011111; else ex -> 6'b001111; else id -> 6'b000111; else if -> 6'b000011; else 6'b000000.
  - In FLUSH, stall = 0 regardless of requests.
- Exception accept:
  - Occurs in RUN when excepttype != 0. Takes priority over any stall request in the same cycle.
  - In the same cycle: flush=1, stall=0, new_pc combinationally selected. excepttype==32'h0000000e (ERET) -> cp0_epc; any other nonzero code -> EXC_VEC.
  - Next edge: state->FLUSH; captured new_pc registered and held; flush counter loaded with FLUSH_CYCLES-1.
- FLUSH state:
  - flush=1; new_pc = registered value. Counter decrements each cycle; at 0 -> RUN.
  - Total flush length is exactly FLUSH_CYCLES cycles including the accept cycle. With FLUSH_CYCLES=1, FLUSH is never entered.
  - excepttype ignored throughout FLUSH (pipeline already cleared).
- flush=0 and new_pc=0 in RUN without an exception.
- Watchdog:
  - 16-bit counter increments each cycle stall!=0 and clears when stall==0 or flush==1.
  - When it reaches STALL_TIMEOUT, timeout_err sets and stays set until reset. Counter then saturates.
- stall_cycles: +1 per cycle with stall!=0; saturates at 32'hFFFFFFFF with no wrap.
- Simultaneous stallreq_mem and excepttype!=0 in RUN: exception wins, stall=0.
- All registered outputs change only on rising clk, except through async reset.

Test Plan:
- Reset: hold rst=0 three cycles with random inputs -> stall=0, flush=0, new_pc=0, timeout_err=0, stall_cycles=0; release -> state RUN.
- Priority: stallreq_id=1 and stallreq_mem=1 -> stall=6'b011111. Drop mem -> 6'b000111. Only stallreq_if -> 6'b000011. stall_cycles counts 3.
- Exception, FLUSH_CYCLES=3: excepttype=32'h00000008 one cycle -> flush=1 for exactly 3 cycles, new_pc=32'h00000040 throughout. A second excepttype=8 on cycle 2 is ignored, giving no extension.
- ERET: cp0_epc=32'h00001234, excepttype=32'h0000000e while stallreq_ex=1 -> same cycle stall=0, flush=1, new_pc=32'h00001234.
- Watchdog, STALL_TIMEOUT=16: stallreq_ex=1 for 15 cycles -> timeout_err=0. One break cycle, then 16 continuous cycles -> timeout_err=1 and stays 1 after the request drops.
- Async reset mid-flush: assert rst=0 between edges during FLUSH -> flush drops immediately without a clock; after release, state=RUN and a new exception flushes normally.
